// File: rtl/dispatch_wide_if.sv
// Bundle between the instruction fetch queue / retire side and the wide dispatch stage.
// Also carries read-only debug views of the dispatch credit state for checkers.
interface dispatch_wide_if #(
  parameter int WIDTH       = 2,
  parameter int ROB_DEPTH   = 32,
  parameter int RS_SLOTS    = 8,
  parameter int NUM_CLASSES = 2,
  parameter int XLEN        = 32
);
  localparam int TAG_W = $clog2(ROB_DEPTH);
  localparam int CLS_W = (NUM_CLASSES > 1) ? $clog2(NUM_CLASSES) : 1;
  localparam int CNT_W = $clog2(WIDTH + 1);
  localparam int RW    = $clog2(ROB_DEPTH + 1);
  localparam int RSW   = $clog2(RS_SLOTS + 1);

  // Handshake: ifq_valid[i] offers lane i; disp_valid[i] in the same cycle is the
  // ready/accept for that lane, and ifq_pop_cnt tells the IFQ how many lanes to drop.
  logic [WIDTH-1:0]             ifq_valid;
  logic [WIDTH*XLEN-1:0]        ifq_instr;
  logic [WIDTH*XLEN-1:0]        ifq_pc;
  logic [WIDTH*CLS_W-1:0]       ifq_class;
  logic [WIDTH-1:0]             ifq_has_rd;
  logic [CNT_W-1:0]             rob_commit_cnt;
  logic [NUM_CLASSES-1:0]       rs_release;
  logic                         flush;
  logic [TAG_W-1:0]             flush_tail;
  logic [WIDTH-1:0]             disp_valid;
  logic [WIDTH*TAG_W-1:0]       disp_tag;
  logic [WIDTH-1:0]             rat_we;
  logic [CNT_W-1:0]             ifq_pop_cnt;
  logic                         stall;
  logic                         partial;
  logic [31:0]                  stall_cycles;
  logic [TAG_W-1:0]             dbg_tail;
  logic [RW-1:0]                dbg_rob_credits;
  logic [NUM_CLASSES*RSW-1:0]   dbg_rs_credits;

  modport master (
    output ifq_valid, ifq_instr, ifq_pc, ifq_class, ifq_has_rd,
           rob_commit_cnt, rs_release, flush, flush_tail,
    input  disp_valid, disp_tag, rat_we, ifq_pop_cnt, stall, partial, stall_cycles,
           dbg_tail, dbg_rob_credits, dbg_rs_credits
  );

  modport slave (
    input  ifq_valid, ifq_instr, ifq_pc, ifq_class, ifq_has_rd,
           rob_commit_cnt, rs_release, flush, flush_tail,
    output disp_valid, disp_tag, rat_we, ifq_pop_cnt, stall, partial, stall_cycles,
           dbg_tail, dbg_rob_credits, dbg_rs_credits
  );
endinterface

// File: rtl/dispatch_wide.sv
// In-order multi-lane dispatch into ROB and per-class reservation stations, driven by
// registered credit counters; grant is combinational from those credits.
module dispatch_wide #(
  parameter int WIDTH       = 2,
  parameter int ROB_DEPTH   = 32,
  parameter int RS_SLOTS    = 8,
  parameter int NUM_CLASSES = 2,
  parameter int XLEN        = 32
) (
  input logic            clk,
  input logic            rst,
  dispatch_wide_if.slave bus
);
  localparam int TAG_W = $clog2(ROB_DEPTH);
  localparam int CLS_W = (NUM_CLASSES > 1) ? $clog2(NUM_CLASSES) : 1;
  localparam int CNT_W = $clog2(WIDTH + 1);
  localparam int RW    = $clog2(ROB_DEPTH + 1);
  localparam int RSW   = $clog2(RS_SLOTS + 1);

  logic [TAG_W-1:0] tail;
  logic [RW-1:0]    rob_credits;
  logic [RSW-1:0]   rs_credits [NUM_CLASSES];
  logic [31:0]      stall_cnt;

  logic [WIDTH-1:0] grant;
  logic [WIDTH-1:0] vprefix;
  logic [CNT_W-1:0] n;
  logic [RSW-1:0]   taken [NUM_CLASSES];

  // A lane is granted only if every older lane was; the chain bit carries that.
  always_comb begin : grant_p
    logic             chain;
    logic             vchain;
    logic [CLS_W-1:0] cls;
    grant   = '0;
    vprefix = '0;
    n       = '0;
    chain   = rst & ~bus.flush;
    vchain  = 1'b1;
    cls     = '0;
    for (int c = 0; c < NUM_CLASSES; c++) taken[c] = '0;
    for (int i = 0; i < WIDTH; i++) begin
      cls        = bus.ifq_class[i*CLS_W +: CLS_W];
      vchain     = vchain & bus.ifq_valid[i];
      vprefix[i] = vchain;
      chain      = chain & bus.ifq_valid[i] & (rob_credits > RW'(i))
                 & (int'(cls) < NUM_CLASSES) & (rs_credits[cls] > taken[cls]);
      grant[i]   = chain;
      if (chain) begin
        taken[cls] = taken[cls] + RSW'(1);
        n          = n + CNT_W'(1);
      end
    end
  end

  logic [RW:0]    rob_sum;
  logic [RW-1:0]  rob_next;
  logic [RSW-1:0] rs_next [NUM_CLASSES];
  logic           rob_ovf;
  logic           rs_ovf;

  // Returns beyond the maximum are protocol errors; the counters clamp instead of wrapping.
  always_comb begin : credit_p
    logic [RSW:0] rs_sum;
    rob_sum  = {1'b0, rob_credits} - (RW+1)'(n) + (RW+1)'(bus.rob_commit_cnt);
    rob_ovf  = rob_sum > (RW+1)'(ROB_DEPTH);
    rob_next = rob_ovf ? RW'(ROB_DEPTH) : rob_sum[RW-1:0];
    rs_ovf   = 1'b0;
    rs_sum   = '0;
    for (int c = 0; c < NUM_CLASSES; c++) begin
      rs_sum     = {1'b0, rs_credits[c]} - {1'b0, taken[c]} + (RSW+1)'(bus.rs_release[c]);
      rs_next[c] = (rs_sum > (RSW+1)'(RS_SLOTS)) ? RSW'(RS_SLOTS) : rs_sum[RSW-1:0];
      rs_ovf     = rs_ovf | (rs_sum > (RSW+1)'(RS_SLOTS));
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      tail        <= '0;
      rob_credits <= RW'(ROB_DEPTH);
      for (int c = 0; c < NUM_CLASSES; c++) rs_credits[c] <= RSW'(RS_SLOTS);
    end else if (bus.flush) begin
      tail        <= bus.flush_tail;
      rob_credits <= RW'(ROB_DEPTH);
      for (int c = 0; c < NUM_CLASSES; c++) rs_credits[c] <= RSW'(RS_SLOTS);
    end else begin
      tail        <= tail + TAG_W'(n);
      rob_credits <= rob_next;
      for (int c = 0; c < NUM_CLASSES; c++) rs_credits[c] <= rs_next[c];
      assert (!(rob_ovf || rs_ovf));
    end
  end

  always_ff @(posedge clk) begin
    if (!rst)                              stall_cnt <= '0;
    else if (bus.stall && stall_cnt != '1) stall_cnt <= stall_cnt + 32'd1;
  end

  for (genvar i = 0; i < WIDTH; i++) begin : g_lane
    assign bus.disp_tag[i*TAG_W +: TAG_W] = tail + TAG_W'(i);
    assign bus.rat_we[i] = grant[i] & bus.ifq_has_rd[i] & (|bus.ifq_instr[i*XLEN+7 +: 5]);
  end

  for (genvar c = 0; c < NUM_CLASSES; c++) begin : g_dbg
    assign bus.dbg_rs_credits[c*RSW +: RSW] = rs_credits[c];
  end

  assign bus.disp_valid      = grant;
  assign bus.ifq_pop_cnt     = n;
  assign bus.stall           = rst & bus.ifq_valid[0] & ~grant[0];
  assign bus.partial         = (|grant) & (grant != vprefix);
  assign bus.stall_cycles    = stall_cnt;
  assign bus.dbg_tail        = tail;
  assign bus.dbg_rob_credits = rob_credits;

  logic unused_ok;
  assign unused_ok = ^{bus.ifq_pc, bus.ifq_instr};
endmodule

// File: tb/tb_dispatch_wide.sv
// Directed plus randomized bench for dispatch_wide; expectations come from an occupancy model
// (entries in flight per ROB and per RS class) evaluated against the dispatch rules.
module tb_dispatch_wide;
  localparam int WIDTH       = 2;
  localparam int ROB_DEPTH   = 4;
  localparam int RS_SLOTS    = 2;
  localparam int NUM_CLASSES = 2;
  localparam int XLEN        = 32;
  localparam int TAG_W       = 2;
  localparam int RSW         = 2;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  dispatch_wide_if #(.WIDTH(WIDTH), .ROB_DEPTH(ROB_DEPTH), .RS_SLOTS(RS_SLOTS),
                     .NUM_CLASSES(NUM_CLASSES), .XLEN(XLEN)) bus ();

  dispatch_wide #(.WIDTH(WIDTH), .ROB_DEPTH(ROB_DEPTH), .RS_SLOTS(RS_SLOTS),
                  .NUM_CLASSES(NUM_CLASSES), .XLEN(XLEN)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int checks = 0;
  int errors = 0;
  logic [TAG_W-1:0] exp_q[$];

  // Reference model: entries currently occupied, not credits.
  int     m_tail;
  int     m_rob_used;
  int     m_rs_used [NUM_CLASSES];
  longint m_stall;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic [1:0] v, input logic [1:0] cls,
                       input logic [4:0] rd0, input logic [4:0] rd1, input logic [1:0] hrd,
                       input logic [1:0] cc, input logic [1:0] rel,
                       input logic fl, input logic [1:0] ft);
    logic [XLEN-1:0] i0, i1;
    i0 = $urandom; i0[11:7] = rd0;
    i1 = $urandom; i1[11:7] = rd1;
    bus.ifq_valid      = v;
    bus.ifq_class      = cls;
    bus.ifq_instr      = {i1, i0};
    bus.ifq_pc         = {$urandom, $urandom};
    bus.ifq_has_rd     = hrd;
    bus.rob_commit_cnt = cc;
    bus.rs_release     = rel;
    bus.flush          = fl;
    bus.flush_tail     = ft;
  endtask

  task automatic idle();
    drive(2'b00, 2'b00, 5'd0, 5'd0, 2'b00, 2'd0, 2'b00, 1'b0, 2'd0);
  endtask

  task automatic cycle();
    logic [WIDTH-1:0] e_dv, e_rat;
    int took [NUM_CLASSES];
    int e_n, vp, cls;
    logic blocked, e_stall, e_partial;
    @(negedge clk);
    e_dv = '0; e_rat = '0; e_n = 0; vp = 0; blocked = 1'b0;
    for (int c = 0; c < NUM_CLASSES; c++) took[c] = 0;
    for (int i = 0; i < WIDTH; i++) begin
      if (vp == i && bus.ifq_valid[i]) vp++;
      cls = int'(bus.ifq_class[i]);
      if (!blocked && rst && !bus.flush && bus.ifq_valid[i] && (i < ROB_DEPTH - m_rob_used)
          && (took[cls] < RS_SLOTS - m_rs_used[cls])) begin
        e_dv[i] = 1'b1;
        took[cls]++;
        e_n++;
        e_rat[i] = bus.ifq_has_rd[i] && (bus.ifq_instr[i*XLEN+7 +: 5] != 5'd0);
      end else begin
        blocked = 1'b1;
      end
    end
    e_stall   = rst && bus.ifq_valid[0] && !e_dv[0];
    e_partial = (e_n > 0) && (e_n < vp);
    chk("disp_valid", 64'(bus.disp_valid), 64'(e_dv));
    chk("rat_we", 64'(bus.rat_we), 64'(e_rat));
    chk("ifq_pop_cnt", 64'(bus.ifq_pop_cnt), 64'(e_n));
    chk("stall", 64'(bus.stall), 64'(e_stall));
    chk("partial", 64'(bus.partial), 64'(e_partial));
    chk("stall_cycles", 64'(bus.stall_cycles), 64'(m_stall));
    chk("tail", 64'(bus.dbg_tail), 64'(m_tail));
    chk("rob_credits", 64'(bus.dbg_rob_credits), 64'(ROB_DEPTH - m_rob_used));
    for (int c = 0; c < NUM_CLASSES; c++)
      chk("rs_credits", 64'(bus.dbg_rs_credits[c*RSW +: RSW]), 64'(RS_SLOTS - m_rs_used[c]));
    for (int i = 0; i < WIDTH; i++)
      if (e_dv[i]) exp_q.push_back(TAG_W'((m_tail + i) % ROB_DEPTH));
    for (int i = 0; i < WIDTH; i++)
      if (e_dv[i] && exp_q.size() > 0) chk("disp_tag", 64'(bus.disp_tag[i*TAG_W +: TAG_W]), 64'(exp_q.pop_front()));
    @(posedge clk);
    if (!rst) begin
      m_tail = 0; m_rob_used = 0; m_stall = 0;
      for (int c = 0; c < NUM_CLASSES; c++) m_rs_used[c] = 0;
    end else begin
      if (e_stall && m_stall < 64'hFFFF_FFFF) m_stall++;
      if (bus.flush) begin
        m_tail = int'(bus.flush_tail); m_rob_used = 0;
        for (int c = 0; c < NUM_CLASSES; c++) m_rs_used[c] = 0;
      end else begin
        m_tail     = (m_tail + e_n) % ROB_DEPTH;
        m_rob_used = m_rob_used + e_n - int'(bus.rob_commit_cnt);
        for (int c = 0; c < NUM_CLASSES; c++)
          m_rs_used[c] = m_rs_used[c] + took[c] - int'(bus.rs_release[c]);
      end
    end
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b0;
    idle();
    cycle();
    rst = 1'b1;
  endtask

  initial begin
    m_tail = 0; m_rob_used = 0; m_stall = 0;
    for (int c = 0; c < NUM_CLASSES; c++) m_rs_used[c] = 0;
    rst = 1'b0;
    idle();
    @(posedge clk); #1;
    do_reset();

    // 1: two lanes, ALU then LSU, rd x5 / x0
    drive(2'b11, 2'b10, 5'd5, 5'd0, 2'b11, 2'd0, 2'b00, 1'b0, 2'd0);
    cycle();
    idle(); cycle();

    // 2: ALU credit down to one, then two ALU lanes -> partial, then stall
    do_reset();
    drive(2'b01, 2'b00, 5'd1, 5'd0, 2'b01, 2'd0, 2'b00, 1'b0, 2'd0); cycle();
    drive(2'b11, 2'b00, 5'd2, 5'd3, 2'b11, 2'd0, 2'b00, 1'b0, 2'd0); cycle();
    drive(2'b11, 2'b00, 5'd2, 5'd3, 2'b11, 2'd0, 2'b00, 1'b0, 2'd0); cycle();
    idle(); cycle();

    // 3: fill ROB, stall, commit one -> one lane dispatches only the next cycle
    do_reset();
    drive(2'b11, 2'b10, 5'd1, 5'd2, 2'b11, 2'd0, 2'b00, 1'b0, 2'd0); cycle();
    drive(2'b11, 2'b10, 5'd3, 5'd4, 2'b11, 2'd0, 2'b00, 1'b0, 2'd0); cycle();
    drive(2'b11, 2'b10, 5'd6, 5'd7, 2'b11, 2'd0, 2'b00, 1'b0, 2'd0); cycle();
    drive(2'b11, 2'b10, 5'd6, 5'd7, 2'b11, 2'd1, 2'b11, 1'b0, 2'd0); cycle();
    drive(2'b11, 2'b10, 5'd6, 5'd7, 2'b11, 2'd0, 2'b00, 1'b0, 2'd0); cycle();

    // 4: tail wrap from 3
    do_reset();
    drive(2'b11, 2'b10, 5'd1, 5'd2, 2'b11, 2'd0, 2'b00, 1'b0, 2'd0); cycle();
    drive(2'b01, 2'b00, 5'd3, 5'd0, 2'b01, 2'd2, 2'b11, 1'b0, 2'd0); cycle();
    drive(2'b11, 2'b10, 5'd8, 5'd9, 2'b11, 2'd0, 2'b00, 1'b0, 2'd0); cycle();

    // 5: flush to tail 2 with lanes offered and credits partly used
    drive(2'b11, 2'b10, 5'd8, 5'd9, 2'b11, 2'd0, 2'b00, 1'b1, 2'd2); cycle();
    idle(); cycle();

    // 6: reset asserted mid-burst
    drive(2'b11, 2'b10, 5'd1, 5'd2, 2'b11, 2'd0, 2'b00, 1'b0, 2'd0); cycle();
    rst = 1'b0; cycle();
    rst = 1'b1; idle(); cycle();

    // random legal traffic
    for (int k = 0; k < 400; k++) begin
      logic [1:0] v, rel, cc;
      int sel, cmax;
      sel  = $urandom_range(0, 3);
      v    = (sel == 0) ? 2'b00 : (sel == 1) ? 2'b01 : 2'b11;
      cmax = (m_rob_used < WIDTH) ? m_rob_used : WIDTH;
      cc   = 2'($urandom_range(0, cmax));
      rel  = 2'b00;
      for (int c = 0; c < NUM_CLASSES; c++)
        if (m_rs_used[c] > 0) rel[c] = 1'($urandom_range(0, 1));
      drive(v, 2'($urandom), 5'($urandom_range(0, 3) == 0 ? 0 : $urandom),
            5'($urandom_range(0, 3) == 0 ? 0 : $urandom), 2'($urandom),
            cc, rel, ($urandom_range(0, 19) == 0), 2'($urandom));
      rst = ($urandom_range(0, 59) != 0);
      cycle();
    end
    rst = 1'b1;
    idle(); cycle();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
